// File: rtl/param_ram_if.sv
// Access bus of the self-clearing parameter RAM.
// Latency: n/a (signal bundle only).
// Backpressure: busy from the RAM side means requests are dropped, not stalled.
//
// Ports (master = requester, slave = RAM):
//   req, we, a, wd, be  access request, write select, word address, data, byte enables
//   clr                 restart the zero-fill sweep
//   rd, rd_valid        registered read data and its one-cycle valid pulse
//   busy                sweep in progress, accesses ignored
//   err                 one-cycle pulse for an out-of-range access
interface param_ram_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  logic                  req;
  logic                  we;
  logic [ADDR_W-1:0]     a;
  logic [DATA_W-1:0]     wd;
  logic [DATA_W/8-1:0]   be;
  logic                  clr;
  logic [DATA_W-1:0]     rd;
  logic                  rd_valid;
  logic                  busy;
  logic                  err;

  modport master (
    output req, we, a, wd, be, clr,
    input  rd, rd_valid, busy, err
  );

  modport slave (
    input  req, we, a, wd, be, clr,
    output rd, rd_valid, busy, err
  );
endinterface

// File: rtl/param_ram.sv
// Single-port RAM with byte-enable writes and a zero-fill sweep after reset/clr.
// Latency: reads return on the accepting edge's registered output (1 cycle).
// Backpressure: while busy (sweep running) requests are silently dropped.
//
// Ports:
//   clk  single clock, rising edge
//   rst  asynchronous active-low reset
//   bus  param_ram_if slave: req/we/a/wd/be/clr in, rd/rd_valid/busy/err out
module param_ram #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = 32
) (
  input  logic       clk,
  input  logic       rst,
  param_ram_if.slave bus
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int NB = DATA_W / 8;
  // Range check is done at no less than 32 bits so DEPTH itself is always
  // representable and upper address bits are never dropped.
  localparam int XW = (ADDR_W > 32) ? ADDR_W : 32;

  typedef enum logic {
    CLEAR = 1'b0,
    IDLE  = 1'b1
  } state_t;

  state_t            state, state_nxt;
  logic [PW-1:0]     ptr, ptr_nxt;
  logic [DATA_W-1:0] mem [DEPTH];

  logic [XW-1:0]     a_x;
  logic              in_range;
  logic [PW-1:0]     idx;
  logic              acc;

  assign a_x      = XW'(bus.a);
  assign in_range = a_x < XW'(DEPTH);
  assign idx      = a_x[PW-1:0];
  // clr wins over a same-cycle request, and nothing is accepted mid-sweep.
  assign acc      = bus.req && !bus.clr && (state == IDLE);
  assign bus.busy = (state == CLEAR);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= CLEAR;
      ptr   <= '0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    if (bus.clr) begin
      state_nxt = CLEAR;
      ptr_nxt   = '0;
    end else if (state == CLEAR) begin
      if (ptr == PW'(DEPTH - 1)) begin
        state_nxt = IDLE;
        ptr_nxt   = '0;
      end else begin
        ptr_nxt = ptr + PW'(1);
      end
    end
  end

  // Memory has no reset; only the sweep zeroes it. Gating on rst keeps edges
  // seen while reset is held from touching word 0.
  always_ff @(posedge clk) begin
    if (rst && state == CLEAR) begin
      mem[ptr] <= '0;
    end else if (acc && bus.we && in_range) begin
      for (int i = 0; i < NB; i++) begin
        if (bus.be[i]) mem[idx][8*i +: 8] <= bus.wd[8*i +: 8];
      end
    end
  end

  // rd_valid/err are pulses: cleared every edge unless an access sets them.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.rd       <= '0;
      bus.rd_valid <= 1'b0;
      bus.err      <= 1'b0;
    end else begin
      bus.rd_valid <= 1'b0;
      bus.err      <= 1'b0;
      if (acc) begin
        bus.err <= !in_range;
        if (!bus.we) begin
          bus.rd       <= in_range ? mem[idx] : '0;
          bus.rd_valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: doc/param_ram.md
PARAM_RAM -- requirements
Module: param_ram

Interface
REQ-001 The module SHALL have parameter DATA_W, default 32, word width in bits, a multiple of 8.
REQ-002 The module SHALL have parameter DEPTH, default 1024, number of words, a value of 2 or more.
REQ-003 The module SHALL have parameter ADDR_W, default 32, width of the word-address port.
REQ-004 Port clk SHALL be: input, 1 bit, the single clock; all state changes on its rising edge.
REQ-005 Port rst SHALL be: input, 1 bit, asynchronous active-low reset.
REQ-006 Port req SHALL be: input, 1 bit, access request for the current cycle.
REQ-007 Port we SHALL be: input, 1 bit, 1 = write and 0 = read; qualified by req.
REQ-008 Port a SHALL be: input, ADDR_W bits, word address.
REQ-009 Port wd SHALL be: input, DATA_W bits, write data.
REQ-010 Port be SHALL be: input, DATA_W/8 bits, byte enables; bit i selects wd[8i+7:8i].
REQ-011 Port clr SHALL be: input, 1 bit, request to restart the zero-fill sweep.
REQ-012 Port rd SHALL be: output, DATA_W bits, registered read data.
REQ-013 Port rd_valid SHALL be: output, 1 bit, one-cycle pulse marking that rd holds a new read result.
REQ-014 Port busy SHALL be: output, 1 bit, high while the clear sweep runs; high means accesses are not accepted.
REQ-015 Port err SHALL be: output, 1 bit, one-cycle pulse marking an out-of-range access (a >= DEPTH).

Function
REQ-016 The FSM SHALL have two states, CLEAR and IDLE; busy SHALL be 1 exactly when the state is CLEAR.
REQ-017 In CLEAR, each rising edge SHALL write all-zero data to word ptr and then increment ptr; ptr is a clog2(DEPTH)-bit register.
REQ-018 The edge that writes word DEPTH-1 SHALL move the FSM to IDLE, so a full sweep takes exactly DEPTH edges.
REQ-019 An access SHALL be accepted when req=1, busy=0 and clr=0 at a rising edge.
REQ-020 For an accepted in-range write, the block SHALL update only the bytes whose be bit is 1; be=0 SHALL leave the word unchanged.
REQ-021 For an accepted write, rd, rd_valid and err SHALL not be updated or asserted, except that an out-of-range write pulses err.
REQ-022 An accepted in-range read SHALL load rd with the stored word and set rd_valid=1 on that edge, giving 1-cycle latency.
REQ-023 rd SHALL hold its value until the next accepted read.
REQ-024 An accepted out-of-range read SHALL load rd=0 and set rd_valid=1 and err=1 together.
REQ-025 An accepted out-of-range write SHALL leave memory unchanged and set err=1.
REQ-026 rd_valid and err SHALL return to 0 on the next edge unless another qualifying access occurs on that edge.
REQ-027 When req=1 while busy=1, the access SHALL be dropped silently: no memory change, no rd_valid, no err.
REQ-028 clr=1 in IDLE SHALL set ptr=0 and move the FSM to CLEAR on that edge.
REQ-029 When clr=1 and req=1 arrive on the same edge, clr SHALL take priority and the access SHALL be dropped.
REQ-030 clr=1 during CLEAR SHALL restart the sweep with ptr=0.
REQ-031 After a clr, busy SHALL stay high for exactly DEPTH further edges.
REQ-032 A read and a write to the same address on consecutive edges SHALL return the newly written data.
REQ-033 Address arithmetic SHALL compare the full ADDR_W-bit value of a against DEPTH with no truncation, so high address bits never alias.

Reset
REQ-034 Assertion of rst (low) SHALL immediately force state=CLEAR, ptr=0, busy=1, rd=0, rd_valid=0 and err=0, without waiting for a clock edge.
REQ-035 Memory contents SHALL NOT be cleared directly by rst; after release, the block SHALL zero them only through the CLEAR sweep.
REQ-036 Reset asserted mid-sweep or mid-access SHALL abandon the operation, and the sweep SHALL restart from word 0 after release.

Verification
REQ-037 Reset release, DEPTH=1024 -> busy=1 for exactly 1024 edges, then busy=0; a read of any address then returns 0 with rd_valid one edge after the request.
REQ-038 Write a=5, wd=32'hDEADBEEF, be=4'b0101, then read a=5 -> rd=32'h00AD00EF.
REQ-039 Read a=1024, and separately write a=32'h0000_0405 -> the read gives rd=0 with rd_valid=1 and err=1 in the same cycle; the write gives err=1 only and memory is unchanged.
REQ-040 Write a=7 with 32'h12345678, then clr=1 together with req=1 (write to a=8) -> the write is dropped, busy=1 for 1024 edges, and a read of a=7 returns 0.
REQ-041 Reset low for 1 cycle at sweep edge 500, or req=1 while busy=1 -> outputs are forced to 0 and busy=1 at once, and the sweep restarts to take 1024 edges; a dropped req produces no rd_valid or err.
